// File: rtl/demux_feed_pkg.sv
// Shared types and widths for the demux feed serializer.
package demux_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CH_W  = 3;
  localparam int CNT_W = 8;

endpackage

// File: rtl/demux_feed_serializer.sv
// Serializes channel-tagged words MSB-first onto the 1:8 demux input,
// holding the channel on S1..S3 for the frame; one-entry hold register.
//
// state | meaning
// IDLE  | no frame in flight, selects keep last channel
// SHIFT | driving shreg MSB on I, one bit per cycle
// GAP   | forced idle spacing between frames, I = 0
module demux_feed_serializer
  import demux_feed_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              I,
  output logic              S1,
  output logic              S2,
  output logic              S3,
  output logic              bit_valid,
  output logic              frame_last,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t            state, state_next;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] hold_data;
  logic [BC_W-1:0]   bitcnt;
  logic [3:0]        gapcnt;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   hold_ch;
  logic              hold_full;
  logic [CNT_W-1:0]  frames_cnt;

  logic transfer;
  logic last_bit;
  logic gap_done;
  logic boundary;
  logic load_hold;
  logic load_direct;
  logic to_hold;

  always_comb begin
    transfer    = in_valid && !hold_full;
    last_bit    = (state == SHIFT) && (bitcnt == LAST_BIT);
    gap_done    = (state == GAP) && (gapcnt == 4'd0);
    // a frame boundary that can start the next frame without passing through GAP/IDLE
    boundary    = (last_bit && (GAP_CYC == 0)) || gap_done;
    load_hold   = boundary && hold_full;
    load_direct = transfer && ((state == IDLE) || (boundary && !hold_full));
    to_hold     = transfer && !load_direct;

    state_next = state;
    case (state)
      IDLE: begin
        if (load_direct) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          if (GAP_CYC > 0)                    state_next = GAP;
          else if (load_hold || load_direct)  state_next = SHIFT;
          else                                state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_done) begin
          if (load_hold || load_direct) state_next = SHIFT;
          else                          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      sel        <= '0;
      hold_data  <= '0;
      hold_ch    <= '0;
      hold_full  <= 1'b0;
      frames_cnt <= '0;
    end else begin
      state <= state_next;

      if (load_hold) begin
        shreg  <= hold_data;
        sel    <= hold_ch;
        bitcnt <= '0;
      end else if (load_direct) begin
        shreg  <= in_data;
        sel    <= in_ch;
        bitcnt <= '0;
      end else if (state == SHIFT) begin
        shreg  <= shreg << 1;
        bitcnt <= bitcnt + BC_W'(1);
      end

      if (load_hold) begin
        hold_full <= 1'b0;
      end else if (to_hold) begin
        hold_data <= in_data;
        hold_ch   <= in_ch;
        hold_full <= 1'b1;
      end

      // gap timer: load on frame end, count down to terminal zero
      if (last_bit && (state_next == GAP)) gapcnt <= GAP_LOAD;
      else if ((state == GAP) && (gapcnt != 4'd0)) gapcnt <= gapcnt - 4'd1;

      if (last_bit) frames_cnt <= frames_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = !hold_full;
  assign bit_valid   = (state == SHIFT);
  assign I           = bit_valid && shreg[DATA_W-1];
  assign frame_last  = last_bit;
  assign S1          = sel[2];
  assign S2          = sel[1];
  assign S3          = sel[0];
  assign frames_sent = frames_cnt;

endmodule

// File: tb/tb_demux_feed_serializer.sv
// Directed bench for demux_feed_serializer with GAP_CYC = 1, 0 and 3 instances.
module tb_demux_feed_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       g1_valid = 1'b0, g1_ready, g1_i, g1_s1, g1_s2, g1_s3, g1_bv, g1_fl;
  logic [7:0] g1_data = '0, g1_frames;
  logic [2:0] g1_ch = '0;
  logic       g0_valid = 1'b0, g0_ready, g0_i, g0_s1, g0_s2, g0_s3, g0_bv, g0_fl;
  logic [7:0] g0_data = '0, g0_frames;
  logic [2:0] g0_ch = '0;
  logic       g3_valid = 1'b0, g3_ready, g3_i, g3_s1, g3_s2, g3_s3, g3_bv, g3_fl;
  logic [7:0] g3_data = '0, g3_frames;
  logic [2:0] g3_ch = '0;

  demux_feed_serializer #(.DATA_W(8), .GAP_CYC(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(g1_valid), .in_ready(g1_ready),
    .in_data(g1_data), .in_ch(g1_ch), .I(g1_i), .S1(g1_s1), .S2(g1_s2), .S3(g1_s3),
    .bit_valid(g1_bv), .frame_last(g1_fl), .frames_sent(g1_frames));

  demux_feed_serializer #(.DATA_W(8), .GAP_CYC(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .in_valid(g0_valid), .in_ready(g0_ready),
    .in_data(g0_data), .in_ch(g0_ch), .I(g0_i), .S1(g0_s1), .S2(g0_s2), .S3(g0_s3),
    .bit_valid(g0_bv), .frame_last(g0_fl), .frames_sent(g0_frames));

  demux_feed_serializer #(.DATA_W(8), .GAP_CYC(3)) u_g3 (
    .clk(clk), .rst_n(rst_n), .in_valid(g3_valid), .in_ready(g3_ready),
    .in_data(g3_data), .in_ch(g3_ch), .I(g3_i), .S1(g3_s1), .S2(g3_s2), .S3(g3_s3),
    .bit_valid(g3_bv), .frame_last(g3_fl), .frames_sent(g3_frames));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    rst_n = 1'b0;
    #12;
    obs = {g1_bv, g1_i, g1_fl, g1_s1, g1_s2, g1_s3, g1_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000001", obs);
    end
    checks++;
    if ({g1_frames, g0_ready, g3_ready} !== {8'd0, 2'b11}) begin
      errors++;
      $display("FAIL reset_frames got %0d rdy %b%b want 0 rdy 11", g1_frames, g0_ready, g3_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    logic [7:0] w;
    logic [5:0] obs, exp;
    w = 8'hA5;
    g1_valid = 1'b1; g1_data = w; g1_ch = 3'd5;
    tick();
    g1_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      obs = {g1_bv, g1_i, g1_fl, g1_s1, g1_s2, g1_s3};
      exp = {1'b1, w[7-j], (j == 7), 3'b101};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_bit%0d got %b want %b", j, obs, exp);
      end
      tick();
    end
    checks++;
    if ({g1_bv, g1_frames} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL single_end bv %b frames %0d want bv 0 frames 1", g1_bv, g1_frames);
    end
    tick();
  endtask

  task automatic test_idle;
    logic [4:0] obs;
    g1_valid = 1'b1; g1_data = 8'h81; g1_ch = 3'd7;
    tick();
    g1_valid = 1'b0;
    repeat (8) tick();
    for (int c = 0; c < 20; c++) begin
      obs = {g1_bv, g1_i, g1_s1, g1_s2, g1_s3};
      checks++;
      if (obs !== 5'b00111) begin
        errors++;
        $display("FAIL idle_cyc%0d got %b want 00111", c, obs);
      end
      tick();
    end
    checks++;
    if (g1_frames !== 8'd2) begin
      errors++;
      $display("FAIL idle_frames got %0d want 2", g1_frames);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] obs, exp;
    g0_valid = 1'b1; g0_data = 8'hFF; g0_ch = 3'd2;
    tick();
    for (int j = 0; j < 16; j++) begin
      obs = {g0_bv, g0_i, g0_fl, g0_s1, g0_s2, g0_s3, g0_ready};
      exp = {1'b1, (j < 8), (j == 7 || j == 15), ((j < 8) ? 3'b010 : 3'b110),
             (j == 0 || j >= 8)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_bit%0d got %b want %b", j, obs, exp);
      end
      if (j == 0) begin g0_data = 8'h00; g0_ch = 3'd6; end
      if (j == 1) g0_valid = 1'b0;
      tick();
    end
    checks++;
    if ({g0_bv, g0_ready, g0_frames} !== {2'b01, 8'd2}) begin
      errors++;
      $display("FAIL b2b_end bv %b rdy %b frames %0d want 0 1 2", g0_bv, g0_ready, g0_frames);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] w1, w2, w3;
    logic [5:0] obs, exp;
    w1 = 8'hC3; w2 = 8'h5A; w3 = 8'h96;
    g3_valid = 1'b1; g3_data = w1; g3_ch = 3'd1;
    tick();
    g3_data = w2; g3_ch = 3'd4;
    for (int j = 0; j < 8; j++) begin
      obs = {g3_bv, g3_i, g3_s1, g3_s2, g3_s3, g3_ready};
      exp = {1'b1, w1[7-j], 3'b001, (j == 0)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bp_f1_bit%0d got %b want %b", j, obs, exp);
      end
      if (j == 1) begin g3_data = w3; g3_ch = 3'd3; end
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      obs = {g3_bv, g3_i, g3_s1, g3_s2, g3_s3, g3_ready};
      checks++;
      if (obs !== 6'b000010) begin
        errors++;
        $display("FAIL bp_gap1_cyc%0d got %b want 000010", g, obs);
      end
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      obs = {g3_bv, g3_i, g3_s1, g3_s2, g3_s3, g3_ready};
      exp = {1'b1, w2[7-j], 3'b100, (j == 0)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bp_f2_bit%0d got %b want %b", j, obs, exp);
      end
      if (j == 1) g3_valid = 1'b0;
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      obs = {g3_bv, g3_i, g3_s1, g3_s2, g3_s3, g3_ready};
      checks++;
      if (obs !== 6'b001000) begin
        errors++;
        $display("FAIL bp_gap2_cyc%0d got %b want 001000", g, obs);
      end
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      obs = {g3_bv, g3_i, g3_s1, g3_s2, g3_s3, g3_ready};
      exp = {1'b1, w3[7-j], 3'b011, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bp_f3_bit%0d got %b want %b", j, obs, exp);
      end
      tick();
    end
    checks++;
    if ({g3_bv, g3_frames} !== {1'b0, 8'd3}) begin
      errors++;
      $display("FAIL bp_end bv %b frames %0d want 0 3", g3_bv, g3_frames);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] w;
    logic [6:0] obs;
    logic [5:0] o6, e6;
    w = 8'h3C;
    g1_valid = 1'b1; g1_data = w; g1_ch = 3'd2;
    tick();
    g1_data = 8'hEE; g1_ch = 3'd7;
    tick();
    g1_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({g1_bv, g1_i, g1_ready} !== 3'b110) begin
      errors++;
      $display("FAIL rst_prebit4 got %b want 110", {g1_bv, g1_i, g1_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {g1_bv, g1_i, g1_fl, g1_s1, g1_s2, g1_s3, g1_ready};
    checks++;
    if (obs !== 7'b0000001 || g1_frames !== 8'd0) begin
      errors++;
      $display("FAIL rst_async got %b frames %0d want 0000001 frames 0", obs, g1_frames);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({g1_bv, g1_frames} !== 9'd0) begin
        errors++;
        $display("FAIL rst_after_cyc%0d bv %b frames %0d want 0 0", c, g1_bv, g1_frames);
      end
    end
    g1_valid = 1'b1; g1_data = w; g1_ch = 3'd2;
    tick();
    g1_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      o6 = {g1_bv, g1_i, g1_fl, g1_s1, g1_s2, g1_s3};
      e6 = {1'b1, w[7-j], (j == 7), 3'b010};
      checks++;
      if (o6 !== e6) begin
        errors++;
        $display("FAIL rst_resend_bit%0d got %b want %b", j, o6, e6);
      end
      tick();
    end
    checks++;
    if (g1_frames !== 8'd1) begin
      errors++;
      $display("FAIL rst_resend_frames got %0d want 1", g1_frames);
    end
    tick();
  endtask

  task automatic test_wrap;
    logic [7:0] nb, want;
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int n = 0; n < 256; n++) begin
      nb = 8'(n);
      g1_valid = 1'b1; g1_data = nb; g1_ch = nb[2:0];
      tick();
      g1_valid = 1'b0;
      repeat (7) tick();
      checks++;
      if (g1_fl !== 1'b1) begin
        errors++;
        $display("FAIL wrap_last%0d got %b want 1", n, g1_fl);
      end
      tick();
      want = 8'(n + 1);
      checks++;
      if (g1_frames !== want) begin
        errors++;
        $display("FAIL wrap_count%0d got %0d want %0d", n, g1_frames, want);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
